// File: rtl/pipelined_subtractor.sv
// Pipelined 32-bit subtractor: a - b is formed as a + ~b + 1 through a
// Kogge-Stone style parallel-prefix carry network (spans 1, 2, 4, 8, 16).
// There are six register banks: one after each prefix level, then the
// output register. A result is visible after the sixth enabled rising edge,
// counting the edge that samples the operands as the first. The carry-in of
// 1 is folded into bit 0 before the first level, so after span 16 every
// group-generate term is the carry out of its bit.
module pipelined_subtractor #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  output logic [DATA_W-1:0] diff,
  output logic              borrow,
  output logic              ovf
);

  // Group generate after one prefix level of the given span.
  function automatic logic [DATA_W-1:0] prefix_g(input logic [DATA_W-1:0] g,
                                                 input logic [DATA_W-1:0] p,
                                                 input int span);
    return g | (p & (g << span));
  endfunction

  // Group propagate after one prefix level; bits below span keep their value.
  function automatic logic [DATA_W-1:0] prefix_p(input logic [DATA_W-1:0] p,
                                                 input int span);
    logic [DATA_W-1:0] low_mask;
    low_mask = ~({DATA_W{1'b1}} << span);
    return p & ((p << span) | low_mask);
  endfunction

  // Final sum formation: {ovf, borrow, diff} from fully resolved carries.
  function automatic logic [DATA_W+1:0] sum_form(input logic [DATA_W-1:0] g,
                                                 input logic [DATA_W-1:0] p,
                                                 input logic sa,
                                                 input logic sb);
    logic [DATA_W-1:0] s;
    logic              o;
    s = p ^ {g[DATA_W-2:0], 1'b1};
    o = (sa != sb) && (s[DATA_W-1] != sa);
    return {o, ~g[DATA_W-1], s};
  endfunction

  logic [DATA_W-1:0] b_n, p_in, g_in, pp_in;

  logic              vld_p1, vld_p2, vld_p3, vld_p4, vld_p5;
  logic [DATA_W-1:0] g_p1, g_p2, g_p3, g_p4, g_p5;
  logic [DATA_W-1:0] pp_p1, pp_p2, pp_p3, pp_p4;
  logic [DATA_W-1:0] pr_p1, pr_p2, pr_p3, pr_p4, pr_p5;
  logic              sa_p1, sa_p2, sa_p3, sa_p4, sa_p5;
  logic              sb_p1, sb_p2, sb_p3, sb_p4, sb_p5;
  logic [DATA_W+1:0] res_p5;

  // Bitwise generate/propagate of a + ~b, with carry-in 1 absorbed into bit 0.
  always_comb begin
    b_n      = ~b;
    p_in     = a ^ b_n;
    g_in     = a & b_n;
    g_in[0]  = g_in[0] | p_in[0];
    pp_in    = p_in;
    pp_in[0] = 1'b0;
  end

  // Sum, borrow and overflow from stage-5 values only.
  always_comb begin
    res_p5 = sum_form(g_p5, pr_p5, sa_p5, sb_p5);
  end

  // Six-bank pipeline; clear flushes everything, en=0 freezes everything.
  always_ff @(posedge clk) begin
    if (clear) begin
      vld_p1 <= 1'b0; vld_p2 <= 1'b0; vld_p3 <= 1'b0; vld_p4 <= 1'b0; vld_p5 <= 1'b0;
      g_p1 <= '0; g_p2 <= '0; g_p3 <= '0; g_p4 <= '0; g_p5 <= '0;
      pp_p1 <= '0; pp_p2 <= '0; pp_p3 <= '0; pp_p4 <= '0;
      pr_p1 <= '0; pr_p2 <= '0; pr_p3 <= '0; pr_p4 <= '0; pr_p5 <= '0;
      sa_p1 <= 1'b0; sa_p2 <= 1'b0; sa_p3 <= 1'b0; sa_p4 <= 1'b0; sa_p5 <= 1'b0;
      sb_p1 <= 1'b0; sb_p2 <= 1'b0; sb_p3 <= 1'b0; sb_p4 <= 1'b0; sb_p5 <= 1'b0;
      out_valid <= 1'b0;
      diff      <= '0;
      borrow    <= 1'b0;
      ovf       <= 1'b0;
    end else if (en) begin
      // stage 1: prefix span 1
      vld_p1 <= in_valid;
      g_p1   <= prefix_g(g_in, pp_in, 1);
      pp_p1  <= prefix_p(pp_in, 1);
      pr_p1  <= p_in;
      sa_p1  <= a[DATA_W-1];
      sb_p1  <= b[DATA_W-1];
      // stage 2: prefix span 2
      vld_p2 <= vld_p1;
      g_p2   <= prefix_g(g_p1, pp_p1, 2);
      pp_p2  <= prefix_p(pp_p1, 2);
      pr_p2  <= pr_p1;
      sa_p2  <= sa_p1;
      sb_p2  <= sb_p1;
      // stage 3: prefix span 4
      vld_p3 <= vld_p2;
      g_p3   <= prefix_g(g_p2, pp_p2, 4);
      pp_p3  <= prefix_p(pp_p2, 4);
      pr_p3  <= pr_p2;
      sa_p3  <= sa_p2;
      sb_p3  <= sb_p2;
      // stage 4: prefix span 8
      vld_p4 <= vld_p3;
      g_p4   <= prefix_g(g_p3, pp_p3, 8);
      pp_p4  <= prefix_p(pp_p3, 8);
      pr_p4  <= pr_p3;
      sa_p4  <= sa_p3;
      sb_p4  <= sb_p3;
      // stage 5: prefix span 16, carries fully resolved so no propagate kept
      vld_p5 <= vld_p4;
      g_p5   <= prefix_g(g_p4, pp_p4, 16);
      pr_p5  <= pr_p4;
      sa_p5  <= sa_p4;
      sb_p5  <= sb_p4;
      // stage 6: output register, zeroed for bubbles
      out_valid <= vld_p5;
      diff      <= vld_p5 ? res_p5[DATA_W-1:0] : '0;
      borrow    <= vld_p5 & res_p5[DATA_W];
      ovf       <= vld_p5 & res_p5[DATA_W+1];
    end
  end

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Bench for pipelined_subtractor: directed literal cases plus a random soak,
// all checked every cycle against a behavioural a-b reference model.
module tb_pipelined_subtractor;

  logic        clk = 1'b0;
  logic        clear = 1'b0;
  logic        en = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic [31:0] diff;
  logic        borrow;
  logic        ovf;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  pipelined_subtractor #(.DATA_W(32)) dut (
    .clk      (clk),
    .clear    (clear),
    .en       (en),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .diff     (diff),
    .borrow   (borrow),
    .ovf      (ovf)
  );

  // Reference arithmetic: plain subtraction, unsigned compare, 33-bit signed range.
  function automatic void ref_result(input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] d, output bit bo, output bit ov);
    logic signed [32:0] sd;
    d  = x - y;
    bo = (x < y);
    sd = $signed({x[31], x}) - $signed({y[31], y});
    ov = (sd[32] != sd[31]);
  endfunction

  // Reference model: operations in flight (five enabled edges) then a result slot.
  bit          mv[5];
  logic [31:0] ma[5];
  logic [31:0] mb[5];
  bit          ev = 1'b0;
  logic [31:0] ed = '0;
  bit          eb = 1'b0;
  bit          eo = 1'b0;
  logic [31:0] td;
  bit          tbo, tov;

  always @(posedge clk) begin
    if (clear) begin
      for (int k = 0; k < 5; k++) mv[k] <= 1'b0;
      ev <= 1'b0; ed <= '0; eb <= 1'b0; eo <= 1'b0;
    end else if (en) begin
      ref_result(ma[4], mb[4], td, tbo, tov);
      ev <= mv[4];
      ed <= mv[4] ? td : 32'd0;
      eb <= mv[4] & tbo;
      eo <= mv[4] & tov;
      mv[0] <= in_valid; ma[0] <= a; mb[0] <= b;
      for (int k = 1; k < 5; k++) begin
        mv[k] <= mv[k-1]; ma[k] <= ma[k-1]; mb[k] <= mb[k-1];
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (out_valid !== ev || diff !== ed || borrow !== eb || ovf !== eo) begin
        errors++;
        $display("FAIL model t=%0t got v=%b d=%h bo=%b ov=%b required v=%b d=%h bo=%b ov=%b",
                 $time, out_valid, diff, borrow, ovf, ev, ed, eb, eo);
      end
    end
  end

  task automatic step(input bit cl, input bit e, input bit iv,
                      input logic [31:0] x, input logic [31:0] y);
    clear = cl; en = e; in_valid = iv; a = x; b = y;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  logic [31:0] ca[3]  = '{32'd3, 32'h8000_0000, 32'h7FFF_FFFF};
  logic [31:0] cb[3]  = '{32'd5, 32'd1, 32'hFFFF_FFFF};
  logic [31:0] cd[3]  = '{32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h8000_0000};
  logic [31:0] cbo[3] = '{32'd1, 32'd0, 32'd1};
  logic [31:0] cov[3] = '{32'd0, 32'd1, 32'd1};

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int issued;
    int s;
    logic [31:0] x, y, negi;
    bit cl, e, iv;

    // reset state
    step(1'b1, 1'b0, 1'b1, 32'd9, 32'd1);
    step(1'b1, 1'b1, 1'b1, 32'd9, 32'd1);
    chk_en = 1'b1;
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_diff", diff, 32'd0);
    chk("reset_flags", {30'd0, borrow, ovf}, 32'd0);

    // 5 - 3, single operation, latency and one-cycle pulse
    step(1'b0, 1'b1, 1'b1, 32'd5, 32'd3);
    for (int k = 1; k <= 5; k++) begin
      idle();
      if (k < 5) chk("lat_early_valid", {31'd0, out_valid}, 32'd0);
    end
    chk("basic_valid", {31'd0, out_valid}, 32'd1);
    chk("basic_diff", diff, 32'd2);
    chk("basic_flags", {30'd0, borrow, ovf}, 32'd0);
    idle();
    chk("basic_pulse_end", {31'd0, out_valid}, 32'd0);

    // corner values back-to-back
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, ca[i], cb[i]);
    for (int edge_n = 4; edge_n <= 8; edge_n++) begin
      idle();
      if (edge_n >= 6) begin
        chk("corner_valid", {31'd0, out_valid}, 32'd1);
        chk("corner_diff", diff, cd[edge_n-6]);
        chk("corner_borrow", {31'd0, borrow}, cbo[edge_n-6]);
        chk("corner_ovf", {31'd0, ovf}, cov[edge_n-6]);
      end
    end
    idle();
    chk("corner_after", {31'd0, out_valid}, 32'd0);

    // en=0 hold of two edges stretches latency to eight edges
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle();
    idle();
    step(1'b0, 1'b0, 1'b1, 32'd123, 32'd456);
    chk("hold_valid", {31'd0, out_valid}, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'd7, 32'd77);
    chk("hold_diff", diff, 32'd0);
    idle();
    idle();
    chk("hold_not_yet", {31'd0, out_valid}, 32'd0);
    idle();
    chk("hold_valid_at_8", {31'd0, out_valid}, 32'd1);
    chk("hold_diff_at_8", diff, 32'd0);
    chk("hold_flags_at_8", {30'd0, borrow, ovf}, 32'd0);

    // clear mid-flight discards everything in the pipe
    step(1'b0, 1'b1, 1'b1, 32'd1, 32'd2);
    step(1'b0, 1'b1, 1'b1, 32'd7, 32'd3);
    step(1'b0, 1'b1, 1'b1, 32'd9, 32'd9);
    step(1'b1, 1'b1, 1'b1, 32'd20, 32'd5);
    for (int k = 0; k < 10; k++) begin
      idle();
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_diff", diff, 32'd0);
    end
    step(1'b0, 1'b1, 1'b1, 32'd10, 32'd4);
    for (int k = 0; k < 5; k++) idle();
    chk("post_clear_valid", {31'd0, out_valid}, 32'd1);
    chk("post_clear_diff", diff, 32'd6);

    // alternating valid/bubble, a=i, b=2i
    for (int t = 0; t < 22; t++) begin
      if (t < 16 && (t % 2) == 0)
        step(1'b0, 1'b1, 1'b1, 32'(t / 2 + 1), 32'(2 * (t / 2 + 1)));
      else
        idle();
      s = t - 5;
      if (s >= 0 && s < 16 && (s % 2) == 0) begin
        negi = 32'd0 - 32'(s / 2 + 1);
        chk("alt_valid", {31'd0, out_valid}, 32'd1);
        chk("alt_diff", diff, negi);
        chk("alt_borrow", {31'd0, borrow}, 32'd1);
      end else begin
        chk("alt_bubble", {31'd0, out_valid}, 32'd0);
      end
    end

    // random soak
    issued = 0;
    while (issued < 10000) begin
      cl = ($urandom_range(0, 299) == 0);
      e  = ($urandom_range(0, 7) != 0);
      iv = ($urandom_range(0, 3) != 0);
      x  = pick();
      y  = pick();
      if (iv && e && !cl) issued++;
      step(cl, e, iv, x, y);
    end
    for (int k = 0; k < 8; k++) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
